serial_lane_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one registered 1-bit serial lane
//  (din->dout flop stage) among NREQ requesters. Grants one requester, clocks

---
 rtl/serial_lane_arbiter_if.sv | 28 ++
 rtl/serial_lane_arbiter.sv | 131 +++++++++++++
 tb/tb_serial_lane_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_lane_arbiter_if.sv
// Handshake and lane bundle between serial requesters and the lane arbiter.
// The arbiter connects through the slave modport; sources and monitors use master.
interface serial_lane_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic            en;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] din;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_id;
    logic            dout;
    logic            dvalid;
    logic            sof;
    logic            eof;
    logic            busy;

    modport master (
        output en, req, din,
        input  gnt, gnt_id, dout, dvalid, sof, eof, busy
    );

    modport slave (
        input  en, req, din,
        output gnt, gnt_id, dout, dvalid, sof, eof, busy
    );
endinterface

// File: rtl/serial_lane_arbiter.sv
// Round-robin arbiter that lends one registered 1-bit serial lane to NREQ requesters,
// one FRAME_LEN-bit frame at a time, with GAP_CYC idle cycles between frames.
module serial_lane_arbiter #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 8,
    parameter int GAP_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    serial_lane_arbiter_if.slave  lane
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gntNext;
    logic [IW-1:0]   r_gntId;
    logic [IW-1:0]   w_gntIdNext;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cntNext;
    logic [GW-1:0]   r_gapCnt;
    logic [GW-1:0]   w_gapCntNext;
    logic            r_dout;
    logic            w_doutNext;
    logic            r_dvalid;
    logic            w_dvalidNext;
    logic            r_sof;
    logic            w_sofNext;
    logic            r_eof;
    logic            w_eofNext;
    logic            w_found;
    logic [IW-1:0]   w_winner;

    // Search starts just past the last grantee, so gnt_id doubles as the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_gntId;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && lane.req[(int'(r_gntId) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = IW'((int'(r_gntId) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_gntNext    = r_gnt;
        w_gntIdNext  = r_gntId;
        w_cntNext    = r_cnt;
        w_gapCntNext = r_gapCnt;
        w_doutNext   = 1'b0;
        w_dvalidNext = 1'b0;
        w_sofNext    = 1'b0;
        w_eofNext    = 1'b0;
        case (r_state)
            IDLE: begin
                if (lane.en && w_found) begin
                    w_stateNext = XFER;
                    w_gntNext   = NREQ'(1) << w_winner;
                    w_gntIdNext = w_winner;
                    w_cntNext   = '0;
                end
            end
            XFER: begin
                w_doutNext   = lane.din[r_gntId];
                w_dvalidNext = 1'b1;
                w_sofNext    = (r_cnt == '0);
                w_eofNext    = (int'(r_cnt) == FRAME_LEN - 1);
                w_cntNext    = r_cnt + CW'(1);
                if (int'(r_cnt) == FRAME_LEN - 1) begin
                    w_gntNext    = '0;
                    w_gapCntNext = '0;
                    w_stateNext  = (GAP_CYC > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                w_gapCntNext = r_gapCnt + GW'(1);
                if (int'(r_gapCnt) >= GAP_CYC - 1) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_gntNext   = '0;
            end
        endcase
    end

    // Reset drops any partial frame; the pointer restarts so requester 0 wins first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gntId  <= IW'(NREQ - 1);
            r_cnt    <= '0;
            r_gapCnt <= '0;
            r_dout   <= 1'b0;
            r_dvalid <= 1'b0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_gnt    <= w_gntNext;
            r_gntId  <= w_gntIdNext;
            r_cnt    <= w_cntNext;
            r_gapCnt <= w_gapCntNext;
            r_dout   <= w_doutNext;
            r_dvalid <= w_dvalidNext;
            r_sof    <= w_sofNext;
            r_eof    <= w_eofNext;
        end
    end

    assign lane.gnt    = r_gnt;
    assign lane.gnt_id = r_gntId;
    assign lane.dout   = r_dout;
    assign lane.dvalid = r_dvalid;
    assign lane.sof    = r_sof;
    assign lane.eof    = r_eof;
    assign lane.busy   = (r_state != IDLE);
endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Scoreboard bench for serial_lane_arbiter: an 8-bit/1-gap build (lane 0) and a
// 1-bit/no-gap build (lane 1) share clock and reset.
module tb_serial_lane_arbiter;
    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int FL   = 8;
    localparam int GC   = 1;

    typedef struct packed {
        logic data;
        logic sof;
        logic eof;
    } laneBit_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   useRandDin = 1'b0;

    laneBit_t        expData[2][$];
    int              expGnt[2][$];
    logic [NREQ-1:0] prevGnt[2];
    int              lowCnt[2];
    int              lenCnt[2];
    bit              seenFrame[2];
    bit              gapCheck[2];

    serial_lane_arbiter_if #(.NREQ(NREQ)) busA ();
    serial_lane_arbiter_if #(.NREQ(NREQ)) busB ();

    serial_lane_arbiter #(.NREQ(NREQ), .FRAME_LEN(FL), .GAP_CYC(GC)) dutA (
        .clk  (clk),
        .rstn (rstn),
        .lane (busA.slave)
    );

    serial_lane_arbiter #(.NREQ(NREQ), .FRAME_LEN(1), .GAP_CYC(0)) dutB (
        .clk  (clk),
        .rstn (rstn),
        .lane (busB.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        busB.din = NREQ'($urandom);
        if (useRandDin) busA.din = NREQ'($urandom);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic e);
        busA.req = r;
        busA.en  = e;
    endtask

    task automatic resetDut();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic waitGrants(input int ln, input int maxCyc);
        int n = 0;
        while (expGnt[ln].size() != 0 && n < maxCyc) begin
            tick();
            n++;
        end
        checkOutput($sformatf("L%0d grants served", ln), expGnt[ln].size(), 0);
    endtask

    task automatic waitFirstGnt(input string tag);
        int n = 0;
        while (busA.gnt == '0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput(tag, busA.gnt != '0, 1);
    endtask

    task automatic waitIdle(input string tag, input int maxCyc);
        int n = 0;
        while ((busA.busy || busA.gnt != '0 || expData[0].size() != 0) && n < maxCyc) begin
            tick();
            n++;
        end
        checkOutput(tag, busA.busy, 0);
    endtask

    // Pushes the bit sampled under grant, pops it when the lane shows dvalid a cycle later.
    task automatic monitorLane(input int ln, input int frameLen, input int gapLen,
                               input logic [NREQ-1:0] g, input logic [IW-1:0] gid,
                               input logic [NREQ-1:0] d, input logic o, input logic v,
                               input logic s, input logic e);
        laneBit_t b;
        int id;
        if (v === 1'b1) begin
            if (expData[ln].size() == 0) begin
                checkOutput($sformatf("L%0d spurious dvalid", ln), 1, 0);
            end else begin
                b = expData[ln].pop_front();
                checkOutput($sformatf("L%0d dout", ln), o, b.data);
                checkOutput($sformatf("L%0d sof", ln), s, b.sof);
                checkOutput($sformatf("L%0d eof", ln), e, b.eof);
            end
        end else begin
            checkOutput($sformatf("L%0d idle lane", ln), {v, o, s, e}, 0);
        end
        checkOutput($sformatf("L%0d onehot", ln), $countones(g) <= 1, 1);
        id = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) id = i;
        if (g != '0 && prevGnt[ln] == '0) begin
            checkOutput($sformatf("L%0d gnt_id", ln), gid, id);
            if (expGnt[ln].size() == 0) checkOutput($sformatf("L%0d spurious grant", ln), id, 99);
            else checkOutput($sformatf("L%0d grant order", ln), id, expGnt[ln].pop_front());
            if (gapCheck[ln] && seenFrame[ln]) checkOutput($sformatf("L%0d gap", ln), lowCnt[ln], gapLen);
            lenCnt[ln] = 0;
        end
        if (g == '0 && prevGnt[ln] != '0) begin
            checkOutput($sformatf("L%0d gnt len", ln), lenCnt[ln], frameLen);
            seenFrame[ln] = 1'b1;
            lowCnt[ln] = 0;
        end
        if (g != '0) begin
            b.data = (id >= 0) ? d[id] : 1'bx;
            b.sof  = (lenCnt[ln] == 0);
            b.eof  = (lenCnt[ln] == frameLen - 1);
            expData[ln].push_back(b);
            lenCnt[ln]++;
        end else begin
            lowCnt[ln]++;
        end
        prevGnt[ln] = g;
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            for (int ln = 0; ln < 2; ln++) begin
                expData[ln].delete();
                prevGnt[ln]   = '0;
                lowCnt[ln]    = 0;
                lenCnt[ln]    = 0;
                seenFrame[ln] = 1'b0;
            end
        end else begin
            monitorLane(0, FL, GC + 1, busA.gnt, busA.gnt_id, busA.din, busA.dout,
                        busA.dvalid, busA.sof, busA.eof);
            monitorLane(1, 1, 1, busB.gnt, busB.gnt_id, busB.din, busB.dout,
                        busB.dvalid, busB.sof, busB.eof);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic       expV;
        pat = 8'b1011_0010;
        gapCheck[0] = 1'b0;
        gapCheck[1] = 1'b0;
        busA.din = '0;
        busB.din = '0;
        busB.req = '0;
        busB.en  = 1'b0;
        applyStimulus('0, 1'b0);

        // Test 1: reset values, then one frame from requester 0 with a fixed pattern.
        tick();
        tick();
        checkOutput("T1 rst gnt", busA.gnt, 0);
        checkOutput("T1 rst gnt_id", busA.gnt_id, NREQ - 1);
        checkOutput("T1 rst dout", busA.dout, 0);
        checkOutput("T1 rst dvalid", busA.dvalid, 0);
        checkOutput("T1 rst sof", busA.sof, 0);
        checkOutput("T1 rst eof", busA.eof, 0);
        checkOutput("T1 rst busy", busA.busy, 0);
        rstn = 1'b1;
        expGnt[0].push_back(0);
        applyStimulus(4'b0001, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) applyStimulus('0, 1'b1);
            busA.din[0] = (c <= 8) ? pat[8 - c] : 1'b0;
            expV = (c >= 2 && c <= 9);
            checkOutput($sformatf("T1 gnt c%0d", c), busA.gnt, (c <= 8) ? 1 : 0);
            checkOutput($sformatf("T1 busy c%0d", c), busA.busy, (c <= 9) ? 1 : 0);
            checkOutput($sformatf("T1 dvalid c%0d", c), busA.dvalid, expV);
            checkOutput($sformatf("T1 dout c%0d", c), busA.dout, expV ? pat[9 - c] : 1'b0);
            checkOutput($sformatf("T1 sof c%0d", c), busA.sof, (c == 2) ? 1 : 0);
            checkOutput($sformatf("T1 eof c%0d", c), busA.eof, (c == 9) ? 1 : 0);
        end
        useRandDin = 1'b1;

        // Test 2: all four requesting from reset, rotation 0,1,2,3,0 with 2-cycle gaps.
        resetDut();
        gapCheck[0] = 1'b1;
        for (int i = 0; i < 5; i++) expGnt[0].push_back(i % NREQ);
        applyStimulus(4'b1111, 1'b1);
        waitGrants(0, 80);
        applyStimulus('0, 1'b1);
        waitIdle("T2 idle", 40);
        gapCheck[0] = 1'b0;

        // Test 3: request dropped mid-frame, frame still completes.
        expGnt[0].push_back(2);
        applyStimulus(4'b0100, 1'b1);
        waitFirstGnt("T3 grant seen");
        tick();
        tick();
        applyStimulus('0, 1'b1);
        waitIdle("T3 idle", 30);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("T3 gnt_id held", busA.gnt_id, 2);

        // Test 4: en dropped mid-frame, no further grants until re-enabled.
        expGnt[0].push_back(0);
        applyStimulus(4'b0011, 1'b1);
        waitFirstGnt("T4 grant seen");
        tick();
        tick();
        tick();
        applyStimulus(4'b0011, 1'b0);
        waitIdle("T4 idle", 30);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("T4 no grant", busA.gnt, 0);
        checkOutput("T4 gnt_id held", busA.gnt_id, 0);
        expGnt[0].push_back(1);
        applyStimulus(4'b0011, 1'b1);
        waitGrants(0, 20);
        applyStimulus('0, 1'b1);
        waitIdle("T4 idle2", 30);

        // Test 5: asynchronous reset at frame bit 4, then requester 0 first again.
        resetDut();
        expGnt[0].push_back(0);
        applyStimulus(4'b0011, 1'b1);
        waitFirstGnt("T5 grant seen");
        tick();
        tick();
        tick();
        rstn = 1'b0;
        #1;
        checkOutput("T5 async gnt", busA.gnt, 0);
        checkOutput("T5 async gnt_id", busA.gnt_id, NREQ - 1);
        checkOutput("T5 async dout", busA.dout, 0);
        checkOutput("T5 async dvalid", busA.dvalid, 0);
        checkOutput("T5 async sof", busA.sof, 0);
        checkOutput("T5 async eof", busA.eof, 0);
        checkOutput("T5 async busy", busA.busy, 0);
        tick();
        tick();
        expGnt[0].push_back(0);
        expGnt[0].push_back(1);
        rstn = 1'b1;
        waitGrants(0, 40);
        applyStimulus('0, 1'b1);
        waitIdle("T5 idle", 30);

        // Test 6: single-bit frames without gap alternate between requesters 1 and 3.
        gapCheck[1] = 1'b1;
        for (int i = 0; i < 6; i++) expGnt[1].push_back((i % 2 == 0) ? 1 : 3);
        busB.req = 4'b1010;
        busB.en  = 1'b1;
        waitGrants(1, 40);
        busB.req = '0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("T6 drained", expData[1].size(), 0);
        checkOutput("T6 busy", busB.busy, 0);
        checkOutput("T6 gnt_id", busB.gnt_id, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
